// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline datapath/test harness and pipeline_control.
// The harness drives hazard inputs and debug commands; the controller returns enables and status.
interface pipeline_control_if #(
  parameter int N_STAGES   = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_MemRead;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  mem_branch_taken;
  logic                  wb_halt;
  logic                  dbg_run;
  logic                  dbg_halt;
  logic                  dbg_step;
  logic                  dbg_clear;

  logic                  pipe_en;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic [N_STAGES-2:0]   flush;
  logic [1:0]            state;
  logic                  halted_by_instr;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_branch_taken, wb_halt,
           dbg_run, dbg_halt, dbg_step, dbg_clear,
    input  pipe_en, pc_write, if_id_write, id_ex_bubble, flush, state, halted_by_instr,
           cycle_count, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_branch_taken, wb_halt,
           dbg_run, dbg_halt, dbg_step, dbg_clear,
    output pipe_en, pc_write, if_id_write, id_ex_bubble, flush, state, halted_by_instr,
           cycle_count, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_control.sv
// Hazard and run-control unit: load-use stall, branch flush, debug run/halt/step FSM
// and performance counters for an N-stage MIPS pipeline.
module pipeline_control #(
  parameter int N_STAGES     = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int RUN_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  pipeline_control_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  localparam state_t RESET_ST = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;
  // Latches younger than the branch-resolving stage are discarded on a taken branch.
  localparam logic [N_STAGES-2:0] BR_MASK = (N_STAGES-1)'((1 << BRANCH_STAGE) - 1);

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic             pipe_en, lu, br;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_cnt_q;

  assign lu = bus.ex_MemRead && (bus.ex_rt != '0) &&
              ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign br = bus.mem_branch_taken;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_ST;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic; halt always wins over run and step while halted.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      ST_RUN: begin
        if (bus.wb_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (bus.dbg_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.dbg_halt) begin
          state_d = ST_HALT;
        end else if (bus.dbg_run) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end else if (bus.dbg_step) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
        if (bus.wb_halt) halted_d = 1'b1;
      end
      default: state_d = RESET_ST;
    endcase
  end

  // Output logic; branch outranks load-use since the stalled instruction is discarded.
  always_comb begin
    pipe_en          = (state_q == ST_RUN) || (state_q == ST_STEP);
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.flush        = '0;
    if (pipe_en) begin
      if (br) begin
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.flush       = BR_MASK;
      end else if (lu) begin
        bus.id_ex_bubble = 1'b1;
      end else begin
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
      end
    end
  end

  // Performance counters; clear outranks increment and works while halted.
  always_ff @(posedge clk) begin
    if (reset || bus.dbg_clear) begin
      cycle_q     <= '0;
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else if (pipe_en) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (lu && !br) stall_q <= stall_q + CNT_W'(1);
      if (br) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pipe_en         = pipe_en;
  assign bus.state           = state_q;
  assign bus.halted_by_instr = halted_q;
  assign bus.cycle_count     = cycle_q;
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: hazards, branch flush, debug FSM, counters, reset.
module tb_pipeline_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  pipeline_control_if #(.N_STAGES(5), .REG_ADDR_W(5), .CNT_W(32)) ifc ();
  pipeline_control_if #(.N_STAGES(5), .REG_ADDR_W(5), .CNT_W(32)) ifc_h ();

  pipeline_control #(.N_STAGES(5), .BRANCH_STAGE(3), .REG_ADDR_W(5), .CNT_W(32), .RUN_ON_RESET(1))
    dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  pipeline_control #(.N_STAGES(5), .BRANCH_STAGE(3), .REG_ADDR_W(5), .CNT_W(32), .RUN_ON_RESET(0))
    dut_h (.clk(clk), .reset(reset), .bus(ifc_h.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.id_rs = '0; ifc.id_rt = '0; ifc.id_uses_rt = 1'b0; ifc.ex_MemRead = 1'b0;
    ifc.ex_rt = '0; ifc.mem_branch_taken = 1'b0; ifc.wb_halt = 1'b0;
    ifc.dbg_run = 1'b0; ifc.dbg_halt = 1'b0; ifc.dbg_step = 1'b0; ifc.dbg_clear = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ifc_h.id_rs = '0; ifc_h.id_rt = '0; ifc_h.id_uses_rt = 1'b0; ifc_h.ex_MemRead = 1'b0;
    ifc_h.ex_rt = '0; ifc_h.mem_branch_taken = 1'b0; ifc_h.wb_halt = 1'b0;
    ifc_h.dbg_run = 1'b0; ifc_h.dbg_halt = 1'b0; ifc_h.dbg_step = 1'b0; ifc_h.dbg_clear = 1'b0;
    reset = 1'b1;
    tick(); tick();
    total++; if (ifc.state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0h want=0", ifc.state); end
    total++; if (ifc.pipe_en !== 1'b1) begin bad++; $display("FAIL reset_pipe_en got=%0b want=1", ifc.pipe_en); end
    total++; if (ifc.pc_write !== 1'b1) begin bad++; $display("FAIL reset_pc_write got=%0b want=1", ifc.pc_write); end
    total++; if (ifc.flush !== 4'b0000) begin bad++; $display("FAIL reset_flush got=%0h want=0", ifc.flush); end
    total++; if (ifc.cycle_count !== 32'd0 || ifc.stall_count !== 32'd0 || ifc.flush_count !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", ifc.cycle_count, ifc.stall_count, ifc.flush_count); end
    total++; if (ifc.halted_by_instr !== 1'b0) begin bad++; $display("FAIL reset_flag got=%0b want=0", ifc.halted_by_instr); end
    total++; if (ifc_h.state !== 2'b01) begin bad++; $display("FAIL reset_halt_state got=%0h want=1", ifc_h.state); end
    total++; if (ifc_h.pc_write !== 1'b0 || ifc_h.pipe_en !== 1'b0) begin
      bad++; $display("FAIL reset_halt_pc_write got=%0b/%0b want=0/0", ifc_h.pc_write, ifc_h.pipe_en); end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    clear_inputs();
    ifc.dbg_clear = 1'b1;
    tick();
    ifc.dbg_clear = 1'b0;
    ifc.ex_MemRead = 1'b1; ifc.ex_rt = 5'd8; ifc.id_rs = 5'd8;
    #1;
    total++; if ({ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble} !== 3'b001) begin
      bad++; $display("FAIL lu_stall got=%0b want=001", {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble}); end
    tick();
    total++; if (ifc.stall_count !== 32'd1) begin bad++; $display("FAIL lu_stall_count got=%0d want=1", ifc.stall_count); end
    ifc.ex_rt = 5'd0; ifc.id_rs = 5'd0;
    #1;
    total++; if ({ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble} !== 3'b110) begin
      bad++; $display("FAIL lu_r0 got=%0b want=110", {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble}); end
    tick();
    ifc.ex_rt = 5'd8; ifc.id_rs = 5'd3; ifc.id_rt = 5'd8; ifc.id_uses_rt = 1'b0;
    #1;
    total++; if ({ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble} !== 3'b110) begin
      bad++; $display("FAIL lu_rt_unused got=%0b want=110", {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble}); end
    tick();
    total++; if (ifc.stall_count !== 32'd1) begin bad++; $display("FAIL lu_no_extra_stall got=%0d want=1", ifc.stall_count); end
    ifc.id_uses_rt = 1'b1;
    #1;
    total++; if (ifc.id_ex_bubble !== 1'b1 || ifc.pc_write !== 1'b0) begin
      bad++; $display("FAIL lu_rt_used got=%0b/%0b want=1/0", ifc.id_ex_bubble, ifc.pc_write); end
    tick();
    total++; if (ifc.stall_count !== 32'd2 || ifc.cycle_count !== 32'd4) begin
      bad++; $display("FAIL lu_counts got=%0d/%0d want=2/4", ifc.stall_count, ifc.cycle_count); end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    ifc.dbg_clear = 1'b1;
    tick();
    ifc.dbg_clear = 1'b0;
    ifc.ex_MemRead = 1'b1; ifc.ex_rt = 5'd8; ifc.id_rs = 5'd8; ifc.mem_branch_taken = 1'b1;
    #1;
    total++; if (ifc.flush !== 4'b0111) begin bad++; $display("FAIL br_flush got=%0b want=0111", ifc.flush); end
    total++; if ({ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble} !== 3'b110) begin
      bad++; $display("FAIL br_enables got=%0b want=110", {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble}); end
    tick();
    total++; if (ifc.flush_count !== 32'd1 || ifc.stall_count !== 32'd0) begin
      bad++; $display("FAIL br_counts got=%0d/%0d want=1/0", ifc.flush_count, ifc.stall_count); end
    clear_inputs();
  endtask

  task automatic test_halt_step();
    int en_cycles;
    clear_inputs();
    ifc.dbg_clear = 1'b1;
    tick();
    ifc.dbg_clear = 1'b0;
    ifc.dbg_halt = 1'b1;
    #1;
    total++; if (ifc.pipe_en !== 1'b1) begin bad++; $display("FAIL halt_latency got=%0b want=1", ifc.pipe_en); end
    tick();
    ifc.dbg_halt = 1'b0;
    total++; if (ifc.state !== 2'b01 || ifc.pipe_en !== 1'b0) begin
      bad++; $display("FAIL halt_state got=%0h/%0b want=1/0", ifc.state, ifc.pipe_en); end
    repeat (10) tick();
    total++; if (ifc.cycle_count !== 32'd1) begin bad++; $display("FAIL halt_frozen got=%0d want=1", ifc.cycle_count); end
    en_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      ifc.dbg_step = 1'b1;
      tick();
      ifc.dbg_step = 1'b0;
      if (ifc.pipe_en === 1'b1) en_cycles++;
      tick();
      if (ifc.pipe_en === 1'b1) en_cycles++;
    end
    total++; if (en_cycles !== 3) begin bad++; $display("FAIL step_enabled_cycles got=%0d want=3", en_cycles); end
    total++; if (ifc.cycle_count !== 32'd4) begin bad++; $display("FAIL step_cycle_count got=%0d want=4", ifc.cycle_count); end
    ifc.dbg_step = 1'b1;
    tick();
    total++; if (ifc.state !== 2'b10) begin bad++; $display("FAIL held_step_1 got=%0h want=2", ifc.state); end
    tick();
    total++; if (ifc.state !== 2'b01) begin bad++; $display("FAIL held_step_2 got=%0h want=1", ifc.state); end
    tick();
    total++; if (ifc.state !== 2'b10) begin bad++; $display("FAIL held_step_3 got=%0h want=2", ifc.state); end
    ifc.dbg_step = 1'b0;
    tick();
    total++; if (ifc.state !== 2'b01 || ifc.cycle_count !== 32'd6) begin
      bad++; $display("FAIL held_step_end got=%0h/%0d want=1/6", ifc.state, ifc.cycle_count); end
    ifc.dbg_run = 1'b1;
    tick();
    ifc.dbg_run = 1'b0;
    total++; if (ifc.state !== 2'b00) begin bad++; $display("FAIL run_state got=%0h want=0", ifc.state); end
  endtask

  task automatic test_instr_halt();
    clear_inputs();
    ifc.wb_halt = 1'b1;
    tick();
    ifc.wb_halt = 1'b0;
    total++; if (ifc.state !== 2'b01 || ifc.halted_by_instr !== 1'b1) begin
      bad++; $display("FAIL wb_halt got=%0h/%0b want=1/1", ifc.state, ifc.halted_by_instr); end
    ifc.dbg_halt = 1'b1; ifc.dbg_run = 1'b1;
    tick();
    ifc.dbg_halt = 1'b0;
    total++; if (ifc.state !== 2'b01 || ifc.halted_by_instr !== 1'b1) begin
      bad++; $display("FAIL halt_beats_run got=%0h/%0b want=1/1", ifc.state, ifc.halted_by_instr); end
    tick();
    ifc.dbg_run = 1'b0;
    total++; if (ifc.state !== 2'b00 || ifc.halted_by_instr !== 1'b0) begin
      bad++; $display("FAIL run_clears_flag got=%0h/%0b want=0/0", ifc.state, ifc.halted_by_instr); end
    ifc.dbg_clear = 1'b1; ifc.mem_branch_taken = 1'b1;
    tick();
    clear_inputs();
    total++; if (ifc.cycle_count !== 32'd0 || ifc.stall_count !== 32'd0 || ifc.flush_count !== 32'd0) begin
      bad++; $display("FAIL clear_wins got=%0d/%0d/%0d want=0/0/0", ifc.cycle_count, ifc.stall_count, ifc.flush_count); end
  endtask

  task automatic test_reset_in_step();
    clear_inputs();
    ifc.mem_branch_taken = 1'b1;
    tick(); tick();
    ifc.mem_branch_taken = 1'b0;
    total++; if (ifc.cycle_count !== 32'd2 || ifc.flush_count !== 32'd2) begin
      bad++; $display("FAIL pre_reset_counts got=%0d/%0d want=2/2", ifc.cycle_count, ifc.flush_count); end
    ifc.wb_halt = 1'b1;
    tick();
    ifc.wb_halt = 1'b0;
    ifc.dbg_step = 1'b1;
    tick();
    total++; if (ifc.state !== 2'b10 || ifc.halted_by_instr !== 1'b1) begin
      bad++; $display("FAIL enter_step got=%0h/%0b want=2/1", ifc.state, ifc.halted_by_instr); end
    reset = 1'b1; ifc.dbg_run = 1'b1; ifc.dbg_halt = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    total++; if (ifc.state !== 2'b00 || ifc.halted_by_instr !== 1'b0 || ifc.pipe_en !== 1'b1) begin
      bad++; $display("FAIL step_reset_state got=%0h/%0b/%0b want=0/0/1", ifc.state, ifc.halted_by_instr, ifc.pipe_en); end
    total++; if (ifc.cycle_count !== 32'd0 || ifc.flush_count !== 32'd0) begin
      bad++; $display("FAIL step_reset_counts got=%0d/%0d want=0/0", ifc.cycle_count, ifc.flush_count); end
  endtask

  task automatic test_hazard_in_halt();
    clear_inputs();
    ifc.dbg_halt = 1'b1; ifc.dbg_clear = 1'b1;
    tick();
    clear_inputs();
    ifc.ex_MemRead = 1'b1; ifc.ex_rt = 5'd9; ifc.id_rs = 5'd9; ifc.mem_branch_taken = 1'b1;
    #1;
    total++; if ({ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble} !== 3'b000 || ifc.flush !== 4'b0000) begin
      bad++; $display("FAIL halt_hazard_outputs got=%0b/%0b want=000/0000", {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble}, ifc.flush); end
    tick();
    total++; if (ifc.stall_count !== 32'd0 || ifc.flush_count !== 32'd0 || ifc.cycle_count !== 32'd0) begin
      bad++; $display("FAIL halt_hazard_counts got=%0d/%0d/%0d want=0/0/0", ifc.stall_count, ifc.flush_count, ifc.cycle_count); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_halt_step();
    test_instr_halt();
    test_reset_in_step();
    test_hazard_in_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
# pipeline_control

Parametrised hazard and run-control unit for the N-stage MIPS pipeline. It drives the PC, the inter-stage latch enables and the flush lines. It resolves load-use hazards by stalling for one cycle and inserting a bubble, and resolves taken branches by flushing the younger stages. It adds a debug run/halt/single-step state machine and performance counters, so the pipeline can be frozen, stepped and inspected from the test harness.

## Interface
- `N_STAGES`, 5: pipeline depth; there are N_STAGES-1 inter-stage latches, indexed 0 (IF/ID) to N_STAGES-2.
- `BRANCH_STAGE`, 3: stage index (IF=0) where `mem_branch_taken` is resolved; legal range 1..N_STAGES-2.
- `REG_ADDR_W`, 5: register-address width.
- `CNT_W`, 32: counter width.
- `RUN_ON_RESET`, 1: 1 means the reset state is RUN; 0 means HALT.
- `clk` in 1: single clock; everything is registered on its rising edge.
- `reset` in 1: synchronous, active-high.
- `id_rs`, `id_rt` in REG_ADDR_W: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt as a source.
- `ex_MemRead` in 1: the instruction in EX is a load.
- `ex_rt` in REG_ADDR_W: load destination of the instruction in EX.
- `mem_branch_taken` in 1: branch taken (PCSrc) at BRANCH_STAGE.
- `wb_halt` in 1: a halt instruction is retiring in WB.
- `dbg_run`, `dbg_halt`, `dbg_step` in 1: debug commands; one-cycle pulses, level-tolerant.
- `dbg_clear` in 1: zero all counters.
- `pipe_en` out 1: global advance enable for PC and all latches.
- `pc_write` out 1: PC update enable.
- `if_id_write` out 1: IF/ID latch load enable.
- `id_ex_bubble` out 1: ID/EX loads all-zero control signals.
- `flush` out N_STAGES-1: flush[k]=1 clears latch k.
- `state` out 2: 00 RUN, 01 HALT, 10 STEP.
- `halted_by_instr` out 1: sticky; set when HALT was entered via `wb_halt`.
- `cycle_count`, `stall_count`, `flush_count` out CNT_W each.

## Operation
- `pipe_en` = (state==RUN or state==STEP).
- Load-use hazard, `lu`: ex_MemRead and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
- Branch flush, `br`: mem_branch_taken.
- When pipe_en is 1:
  - br=1: flush[k]=1 for k<BRANCH_STAGE, other bits 0; pc_write=1, if_id_write=1, id_ex_bubble=0. Branch has priority over lu, because the stalled instruction is being discarded anyway.
  - lu=1 and br=0: pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0.
  - Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0, flush=0.
- When pipe_en is 0: pc_write=0, if_id_write=0, id_ex_bubble=0, flush=0. lu and br are ignored and not counted.
- FSM transitions, with priority listed top to bottom in each state:
  - RUN: dbg_halt or wb_halt goes to HALT. wb_halt also sets halted_by_instr. dbg_step is ignored.
  - HALT: dbg_halt stays in HALT (halt wins over run and step). dbg_run goes to RUN and clears halted_by_instr. dbg_step goes to STEP.
  - STEP: always goes to HALT after one cycle. wb_halt during STEP sets halted_by_instr.
- Counters are only updated when pipe_en=1:
  - cycle_count +1 every cycle.
  - stall_count +1 when lu and not br.
  - flush_count +1 when br.
- Counters wrap modulo 2^CNT_W. dbg_clear zeroes all three and takes precedence over increment in the same cycle.

## Timing
- Reset values: state = RUN if RUN_ON_RESET else HALT; counters 0; halted_by_instr 0. pipe_en follows state. Other outputs follow the combinational rules above.
- Hazard outputs are combinational from the inputs and the current state, with zero latency. They must settle within the same cycle the latches sample.
- State, flag and counters are registered; commands take effect one cycle after they are sampled.
- Halt latency is exactly 1 cycle: the cycle in which dbg_halt is sampled still advances.
- A step gives exactly one pipe_en=1 cycle per dbg_step sampled in HALT. A held dbg_step gives alternating STEP/HALT cycles.
- A load-use stall lasts one enabled cycle. Once the bubble is in EX, lu deasserts naturally.
- Reset asserted in any state, including mid-STEP, returns to the reset values on the next edge. Reset overrides all commands.

## Test plan
- Reset with RUN_ON_RESET=1: state=00, pipe_en=1, all counters 0, flush=0. With RUN_ON_RESET=0: state=01, pc_write=0.
- ex_MemRead=1, ex_rt=8, id_rs=8: same cycle gives pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count reads 1 next cycle. Repeat with ex_rt=0, then with id_rt=8 and id_uses_rt=0: no stall in either case.
- mem_branch_taken=1 together with the load-use condition: flush=4'b0111 (BRANCH_STAGE=3), id_ex_bubble=0, pc_write=1; flush_count+1, stall_count unchanged.
- dbg_halt in RUN: next cycle state=01 and pipe_en=0; cycle_count frozen for 10 cycles. Three dbg_step pulses: exactly 3 pipe_en=1 cycles, cycle_count+3. dbg_run returns to state=00.
- wb_halt in RUN gives HALT with halted_by_instr=1. dbg_halt and dbg_run together stay in HALT. dbg_run alone clears the flag. dbg_clear during an increment cycle reads 0 next cycle.
- Reset asserted in STEP with nonzero counters: next cycle gives the reset values. A lu hazard while in HALT gives id_ex_bubble=0 and no stall_count change.
